thread_sched_rr: RTL and testbench
==================================

# thread_sched_rr

Round-robin thread scheduler for the sha256crypt CPU, replacing look-ahead scanning of the thread-state memory with an internal per-thread ready bitmap. It mirrors thread-state writes, selects the next `WR_RDY` thread in a single cycle, and signals the CPU to reload context. It also handles the init traversal on entry-point switches and the hold-off that keeps a just-released thread from being re-picked before its state write lands. It sits between the thread-state memory write port and the CPU's context-reload logic.

## Interface
- `N_THREADS`, 16: number of hardware threads; any value ≥2, not necessarily a power of 2.
- `N_THREADS_MSB`, `` `MSB(N_THREADS-1) ``: thread-index MSB.
- `TS_DELAY`, 2: cycles a released thread stays excluded from selection; ≥1.
- `CNT_WIDTH`, 32: width of the suspended-cycles counter.
- `CLK` in 1: clock. Single clock domain.
- `RST` in 1: reset, synchronous, active-high.
- `entry_pt_switch` in 1: restart init traversal.
- `ts_wr_en` in 1: thread-state write strobe, mirrored from the thread_state memory.
- `ts_wr_num` in `N_THREADS_MSB+1`: thread being written.
- `ts_wr_state` in `` `THREAD_STATE_MSB+1 ``: state being written.
- `NEXT_THREAD` in 1: CPU releases the current thread.
- `RELOAD` out 1: a new thread is being selected this cycle; load its context.
- `thread_num` out `N_THREADS_MSB+1`: current thread (registered).
- `thread_init` out 1: init traversal in progress (registered).
- `suspended` out 1: no thread is running (registered).
- `cycles_suspended` out `CNT_WIDTH`: saturating count of suspended cycles outside init.

## Operation
- **Ready bitmap `rdy[N_THREADS]`**
  - On `ts_wr_en`, `rdy[ts_wr_num]` is set to (`ts_wr_state` == `` `THREAD_STATE_WR_RDY ``).
  - On `RELOAD`, `rdy[cand]` is cleared because the thread is now running.
  - If the same thread is both written and reloaded in one cycle, the write wins.
- **Hold-off**
  - On `NEXT_THREAD` (outside init), `hold_cnt` is loaded with `TS_DELAY`.
  - `hold_cnt` decrements to 0 each subsequent cycle.
  - While `hold_cnt` ≠ 0, `thread_num` is masked out of selection.
- **Candidate selection**
  - `cand`/`cand_vld` is the first set bit of `rdy & ~hold_mask`.
  - Search starts at `thread_num+1` and wraps at `N_THREADS-1` to 0; `thread_num` itself is searched last.
  - Combinational from registered state only; it does not depend on inputs in the same cycle.
- **`RELOAD`** = `~thread_init & cand_vld & (suspended | NEXT_THREAD)`. When it asserts, `thread_num` ≤ `cand` and `suspended` ≤ 0.
- **`NEXT_THREAD` with `~cand_vld`**: `suspended` ≤ 1; `thread_num` holds.
- **`NEXT_THREAD` while `suspended`**: ignored beyond the `RELOAD` equation above. The CPU does not issue it in this state.
- **State machine**, states INIT, RUN, SUSP:
  - INIT → SUSP when the traversal completes.
  - SUSP → RUN on `RELOAD`.
  - RUN → RUN on `NEXT_THREAD` with `RELOAD`.
  - RUN → SUSP on `NEXT_THREAD` with `~cand_vld`.
  - Any state → INIT on `entry_pt_switch`.
- **Init traversal**
  - `thread_num` steps 0,1,…,`N_THREADS-1`, one step per cycle.
  - On the cycle `thread_num` = `N_THREADS-1`, `thread_init` ≤ 0 and `suspended` ≤ 1.
  - `NEXT_THREAD` is ignored during init.
  - The bitmap keeps tracking writes during init.
- **`entry_pt_switch`** (any state, including mid-init): next cycle `thread_init` = 1, `thread_num` = 0, `hold_cnt` = 0. It has priority over `RELOAD` and `NEXT_THREAD`.
- **Counter**: `cycles_suspended` increments when `suspended & ~thread_init`, and saturates at all-ones.

## Timing
- Reset values:
  - `thread_num` = 0
  - `thread_init` = 1
  - `suspended` = 1
  - `rdy` = 0
  - `hold_cnt` = 0
  - `cycles_suspended` = 0
  - `RELOAD` = 0, because it is gated by `thread_init`.
- `RST` has priority over every other input.
- `NEXT_THREAD` at cycle t → `RELOAD` at t (combinational) → new `thread_num` visible at t+1.
- `WR_RDY` write at t while suspended → `rdy` set at t+1 → `RELOAD` at t+1 → `thread_num` at t+2.
- A released thread is reselectable no earlier than TS_DELAY+1 cycles after its `NEXT_THREAD`.
- Init takes exactly `N_THREADS` cycles from deassertion of `RST` or `entry_pt_switch`.
- No combinational path from any input except `NEXT_THREAD` to `RELOAD`.

## Structure
- The shared header `sha256.vh` supplies `` `MSB ``, `` `THREAD_STATE_MSB `` and `` `THREAD_STATE_WR_RDY ``. The block adds no new constants.
- Sub-module `rr_find_first #(N)`:
  - Inputs: `mask[N]`, `start`.
  - Outputs: `idx`, `vld`.
  - Implementation: double-width rotate plus priority encode; purely combinational.
- The scheduler holds the bitmap, hold-off counter, state registers and perf counter.

## Test plan
- **Reset/init**, `N_THREADS`=4:
  - Release `RST` → `thread_num` 0,1,2,3 on consecutive cycles.
  - Then `thread_init`=0 and `suspended`=1; `RELOAD` stays 0 throughout.
- **Wake from suspend**: write thread 2 `WR_RDY` at t → `RELOAD`=1 at t+1, `thread_num`=2 at t+2, `suspended`=0, `rdy[2]`=0.
- **Round-robin order**:
  - Setup: threads 0,1,3 ready, current = 1.
  - `NEXT_THREAD` → 3, then → 0; thread 1 is not picked until it is re-marked ready.
- **Hold-off**, `TS_DELAY`=2:
  - Only thread 2 running; re-mark 2 `WR_RDY` in the same cycle as `NEXT_THREAD`.
  - Required: `suspended`=1, and `RELOAD` asserts 3 cycles after `NEXT_THREAD`.
- **Simultaneous events**:
  - `entry_pt_switch` together with `NEXT_THREAD` and a ready candidate → no `thread_num` jump to the candidate; `thread_num`=0 and `thread_init`=1 next cycle.
  - Write plus `RELOAD` on the same thread → `rdy` follows the written state.
- **Counter**: hold suspended 10 cycles with `CNT_WIDTH`=3 → `cycles_suspended` saturates at 7.

Source files
------------

// File: rtl/thread_sched_rr_pkg.sv
// Shared thread-state encoding, scheduler FSM states and index-width helper.
// No logic; constants only.
// No flow control.
package thread_sched_rr_pkg;

    // Thread-state word as written into the thread_state memory by the CPU.
    localparam int THREAD_STATE_MSB = 3;
    localparam logic [THREAD_STATE_MSB:0] THREAD_STATE_WR_RDY = 4'd2;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_SUSP = 2'd2
    } sched_state_e;

    // Bits needed to hold a thread index 0..n-1.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/thread_sched_rr_if.sv
// Bundle between the CPU / thread-state write port and the scheduler.
// Wires only; no latency.
// No flow control: writes and releases are single-cycle strobes.
interface thread_sched_rr_if
    import thread_sched_rr_pkg::*;
#(
    parameter int N_THREADS = 16,
    parameter int CNT_WIDTH = 32
);
    localparam int TW = idx_w(N_THREADS);

    logic                      entry_pt_switch;
    logic                      ts_wr_en;
    logic [TW-1:0]             ts_wr_num;
    logic [THREAD_STATE_MSB:0] ts_wr_state;
    logic                      NEXT_THREAD;
    logic                      RELOAD;
    logic [TW-1:0]             thread_num;
    logic                      thread_init;
    logic                      suspended;
    logic [CNT_WIDTH-1:0]      cycles_suspended;

    modport master (
        output entry_pt_switch, ts_wr_en, ts_wr_num, ts_wr_state, NEXT_THREAD,
        input  RELOAD, thread_num, thread_init, suspended, cycles_suspended
    );

    modport slave (
        input  entry_pt_switch, ts_wr_en, ts_wr_num, ts_wr_state, NEXT_THREAD,
        output RELOAD, thread_num, thread_init, suspended, cycles_suspended
    );

endinterface

// File: rtl/thread_sched_rr_find_first.sv
// Round-robin find-first: lowest set bit of mask at or after start, wrapping.
// Purely combinational, zero latency.
// No flow control.
module rr_find_first #(
    parameter int N = 16,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] mask,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         vld
);
    localparam logic [W:0] N_L = N[W:0];

    logic [N-1:0] w_rot;
    logic [W-1:0] w_off;
    logic [W:0]   w_sum;

    // Rotate so bit 'start' lands at 0, encode the lowest set bit, map back to a thread index.
    always_comb begin
        w_rot = N'({mask, mask} >> start);
        vld   = |w_rot;
        w_off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) w_off = i[W-1:0];
        end
        w_sum = {1'b0, start} + {1'b0, w_off};
        idx   = W'((w_sum >= N_L) ? (w_sum - N_L) : w_sum);
    end

endmodule

// File: rtl/thread_sched_rr.sv
// Round-robin thread scheduler with a mirrored per-thread ready bitmap.
// RELOAD is same-cycle (comb from NEXT_THREAD and registered state); thread_num updates next cycle.
// No backpressure: NEXT_THREAD with nothing ready parks the scheduler in the suspended state.
module thread_sched_rr
    import thread_sched_rr_pkg::*;
#(
    parameter int N_THREADS = 16,
    parameter int TS_DELAY  = 2,
    parameter int CNT_WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    thread_sched_rr_if.slave bus
);
    localparam int TW = idx_w(N_THREADS);
    localparam int HW = $clog2(TS_DELAY + 1);
    localparam logic [TW-1:0] LAST = TW'(N_THREADS - 1);

    sched_state_e         r_state;
    sched_state_e         w_next_state;
    logic [TW-1:0]        r_thread_num;
    logic [N_THREADS-1:0] r_rdy;
    logic [HW-1:0]        r_hold;
    logic [CNT_WIDTH-1:0] r_cnt;

    logic                 w_init;
    logic                 w_susp;
    logic [TW-1:0]        w_start;
    logic [N_THREADS-1:0] w_avail;
    logic [TW-1:0]        w_cand;
    logic                 w_cand_vld;
    logic                 w_reload;
    logic                 w_take;

    // Search begins just after the current thread so the current thread is considered last;
    // a just-released thread is hidden until its hold-off expires.
    always_comb begin
        w_start = (r_thread_num == LAST) ? '0 : r_thread_num + TW'(1);
        w_avail = r_rdy;
        if (r_hold != '0) w_avail = r_rdy & ~(N_THREADS'(1) << r_thread_num);
    end

    rr_find_first #(.N(N_THREADS), .W(TW)) u_find (
        .mask  (w_avail),
        .start (w_start),
        .idx   (w_cand),
        .vld   (w_cand_vld)
    );

    // Reload depends only on registered state plus NEXT_THREAD; entry_pt_switch overrides its effects.
    always_comb begin
        w_reload = ~w_init & w_cand_vld & (w_susp | bus.NEXT_THREAD);
        w_take   = w_reload & ~bus.entry_pt_switch;
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) r_state <= ST_INIT;
        else     r_state <= w_next_state;
    end

    // FSM next-state: entry point switch restarts init from any state.
    always_comb begin
        w_next_state = r_state;
        if (bus.entry_pt_switch) begin
            w_next_state = ST_INIT;
        end else begin
            case (r_state)
                ST_INIT: if (r_thread_num == LAST)                w_next_state = ST_SUSP;
                ST_SUSP: if (w_reload)                            w_next_state = ST_RUN;
                ST_RUN:  if (bus.NEXT_THREAD && !w_cand_vld)      w_next_state = ST_SUSP;
                default:                                          w_next_state = ST_INIT;
            endcase
        end
    end

    // FSM outputs: both flags come straight from the state register.
    always_comb begin
        w_init = (r_state == ST_INIT);
        w_susp = (r_state != ST_RUN);
    end

    // Current thread: steps through every thread during init, otherwise follows reloads.
    always_ff @(posedge CLK) begin
        if (RST || bus.entry_pt_switch)                 r_thread_num <= '0;
        else if (w_init && (r_thread_num != LAST))      r_thread_num <= r_thread_num + TW'(1);
        else if (!w_init && w_reload)                   r_thread_num <= w_cand;
    end

    // Ready bitmap: a reloaded thread is no longer ready, but a same-cycle state write wins.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rdy <= '0;
        end else begin
            if (w_take) r_rdy[w_cand] <= 1'b0;
            if (bus.ts_wr_en && (int'(bus.ts_wr_num) < N_THREADS))
                r_rdy[bus.ts_wr_num] <= (bus.ts_wr_state == THREAD_STATE_WR_RDY);
        end
    end

    // Hold-off: keep a released thread out of selection until its state write has landed.
    always_ff @(posedge CLK) begin
        if (RST || bus.entry_pt_switch)        r_hold <= '0;
        else if (bus.NEXT_THREAD && !w_init)   r_hold <= HW'(TS_DELAY);
        else if (r_hold != '0)                 r_hold <= r_hold - HW'(1);
    end

    // Saturating count of cycles with no thread running outside init.
    always_ff @(posedge CLK) begin
        if (RST)                                   r_cnt <= '0;
        else if (w_susp && !w_init && !(&r_cnt))   r_cnt <= r_cnt + CNT_WIDTH'(1);
    end

    assign bus.RELOAD           = w_reload;
    assign bus.thread_num       = r_thread_num;
    assign bus.thread_init      = w_init;
    assign bus.suspended        = w_susp;
    assign bus.cycles_suspended = r_cnt;

endmodule

// File: tb/tb_thread_sched_rr.sv
// Scoreboarded bench for thread_sched_rr: directed scenarios then random traffic.
// Expected outputs come from an array-based reference model, one record per cycle.
// A negedge monitor pops and compares every cycle.
module tb_thread_sched_rr;
    import thread_sched_rr_pkg::*;

    localparam int N    = 4;
    localparam int TD   = 2;
    localparam int CW   = 3;
    localparam int TW   = idx_w(N);
    localparam int CMAX = (1 << CW) - 1;
    localparam int WR   = int'(THREAD_STATE_WR_RDY);

    typedef struct {
        logic          reload;
        logic [TW-1:0] tn;
        logic          init;
        logic          susp;
        logic [CW-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    thread_sched_rr_if #(.N_THREADS(N), .CNT_WIDTH(CW)) bus ();

    thread_sched_rr #(.N_THREADS(N), .TS_DELAY(TD), .CNT_WIDTH(CW)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model state
    bit m_init, m_susp;
    int m_tn, m_hold, m_cnt;
    bit m_rdy[N];

    function automatic void m_reset();
        m_init = 1; m_susp = 1; m_tn = 0; m_hold = 0; m_cnt = 0;
        for (int i = 0; i < N; i++) m_rdy[i] = 0;
    endfunction

    // First ready thread after the current one, wrapping; current thread last and hidden during hold-off.
    function automatic void m_find(output bit vld, output int cand);
        vld = 0; cand = 0;
        for (int k = 1; k <= N; k++) begin
            int t;
            t = (m_tn + k) % N;
            if (!vld && m_rdy[t] && !(m_hold != 0 && t == m_tn)) begin
                vld = 1; cand = t;
            end
        end
    endfunction

    function automatic void m_update(bit e, bit we, int wn, int ws, bit nt, bit vld, int cand, bit rl);
        if (m_susp && !m_init && m_cnt < CMAX) m_cnt++;
        if (rl && !e) m_rdy[cand] = 0;
        if (we) m_rdy[wn] = (ws == WR);
        if (e) m_hold = 0;
        else if (nt && !m_init) m_hold = TD;
        else if (m_hold > 0) m_hold--;
        if (e) begin
            m_init = 1; m_susp = 1; m_tn = 0;
        end else if (m_init) begin
            if (m_tn == N - 1) begin m_init = 0; m_susp = 1; end
            else m_tn++;
        end else if (rl) begin
            m_tn = cand; m_susp = 0;
        end else if (nt && !vld) begin
            m_susp = 1;
        end
    endfunction

    // Drive one cycle of inputs (called #1 after posedge), queue the expectation, advance the model.
    task automatic step(input bit e, input bit we, input int wn, input int ws, input bit nt);
        bit vld; int cand; bit rl; exp_t x;
        bus.entry_pt_switch = e;
        bus.ts_wr_en        = we;
        bus.ts_wr_num       = wn[TW-1:0];
        bus.ts_wr_state     = ws[THREAD_STATE_MSB:0];
        bus.NEXT_THREAD     = nt;
        m_find(vld, cand);
        rl = !m_init && vld && (m_susp || nt);
        x.reload = rl; x.tn = TW'(m_tn); x.init = m_init; x.susp = m_susp; x.cnt = CW'(m_cnt);
        exp_q.push_back(x);
        @(posedge clk);
        m_update(e, we, wn, ws, nt, vld, cand, rl);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string nm, input int act, input int expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.entry_pt_switch = 0; bus.ts_wr_en = 0; bus.ts_wr_num = '0;
        bus.ts_wr_state = '0; bus.NEXT_THREAD = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_thread_num", int'(bus.thread_num), 0);
        chk("rst_thread_init", int'(bus.thread_init), 1);
        chk("rst_suspended", int'(bus.suspended), 1);
        chk("rst_cycles_suspended", int'(bus.cycles_suspended), 0);
        chk("rst_reload", int'(bus.RELOAD), 0);
        m_reset();
        rst = 1'b0;
    endtask

    // Monitor: compare every cycle's outputs against the queued expectation.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                x = exp_q.pop_front();
                vectors++;
                if (bus.RELOAD !== x.reload || bus.thread_num !== x.tn || bus.thread_init !== x.init ||
                    bus.suspended !== x.susp || bus.cycles_suspended !== x.cnt) begin
                    miscompares++;
                    $display("FAIL cycle_outputs t=%0t: got reload=%b tn=%0d init=%b susp=%b cnt=%0d, expected reload=%b tn=%0d init=%b susp=%b cnt=%0d",
                             $time, bus.RELOAD, bus.thread_num, bus.thread_init, bus.suspended, bus.cycles_suspended,
                             x.reload, x.tn, x.init, x.susp, x.cnt);
                end
            end
        end
    end

    initial begin
        #200000;
        miscompares++;
        $display("FAIL timeout: simulation did not complete within time limit");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "timeout");
    end

    // Stimulus
    initial begin
        bit e, we, nt;
        int wn, ws;

        do_reset();

        // Init traversal: thread_num walks 0..N-1, then suspended with init done.
        chk("init_tn_0", int'(bus.thread_num), 0);
        for (int i = 1; i < N; i++) begin
            idle();
            chk("init_tn_step", int'(bus.thread_num), i);
            chk("init_flag", int'(bus.thread_init), 1);
        end
        idle();
        chk("init_done", int'(bus.thread_init), 0);
        chk("init_susp", int'(bus.suspended), 1);

        // Wake from suspend on a WR_RDY write.
        step(0, 1, 2, WR, 0);
        chk("wake_still_susp", int'(bus.suspended), 1);
        idle();
        chk("wake_tn", int'(bus.thread_num), 2);
        chk("wake_running", int'(bus.suspended), 0);

        // Round-robin ordering.
        step(0, 1, 1, WR, 0);
        step(0, 0, 0, 0, 1);
        chk("rr_to_1", int'(bus.thread_num), 1);
        step(0, 1, 0, WR, 0);
        step(0, 1, 3, WR, 0);
        step(0, 0, 0, 0, 1);
        chk("rr_to_3", int'(bus.thread_num), 3);
        step(0, 0, 0, 0, 1);
        chk("rr_to_0", int'(bus.thread_num), 0);
        step(0, 0, 0, 0, 1);
        chk("rr_none_susp", int'(bus.suspended), 1);
        chk("rr_none_tn_holds", int'(bus.thread_num), 0);
        repeat (3) idle();

        // Hold-off: released thread re-marked ready in the same cycle.
        step(0, 1, 2, WR, 0);
        idle();
        chk("hold_setup_tn", int'(bus.thread_num), 2);
        step(0, 1, 2, WR, 1);
        chk("hold_susp_t1", int'(bus.suspended), 1);
        idle();
        chk("hold_susp_t2", int'(bus.suspended), 1);
        idle();
        chk("hold_susp_t3", int'(bus.suspended), 1);
        idle();
        chk("hold_reload_done", int'(bus.suspended), 0);
        chk("hold_reload_tn", int'(bus.thread_num), 2);
        repeat (3) idle();

        // entry_pt_switch beats NEXT_THREAD and a ready candidate.
        step(0, 1, 0, WR, 0);
        step(1, 0, 0, 0, 1);
        chk("eps_tn", int'(bus.thread_num), 0);
        chk("eps_init", int'(bus.thread_init), 1);
        step(0, 1, 0, 0, 1);
        repeat (3) idle();
        chk("eps_init_done", int'(bus.thread_init), 0);

        // Same-cycle write and reload of one thread: the write is kept.
        step(0, 1, 1, WR, 0);
        step(0, 1, 1, WR, 0);
        chk("wr_rl_tn", int'(bus.thread_num), 1);
        step(0, 0, 0, 0, 1);
        chk("wr_rl_still_ready", int'(bus.suspended), 0);
        step(0, 0, 0, 0, 1);
        repeat (3) idle();

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            e  = ($urandom_range(99) < 2);
            we = $urandom_range(1);
            wn = $urandom_range(N - 1);
            ws = ($urandom_range(1) == 1) ? WR : int'($urandom_range(15));
            nt = (m_init || !m_susp) && ($urandom_range(99) < 35);
            step(e, we, wn, ws, nt);
        end

        // Counter saturation after a fresh reset.
        do_reset();
        repeat (N) idle();
        repeat (3) idle();
        chk("cnt_after_3", int'(bus.cycles_suspended), 3);
        repeat (7) idle();
        chk("cnt_saturated", int'(bus.cycles_suspended), CMAX);

        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
